// File: rtl/corelet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : corelet_ctrl
//  Purpose  : Convolution-pass sequencer. For each kernel position kij it
//             fills L0 with weights, loads them into the array, waits out the
//             load gap, fills L0 with activations, executes, then drains the
//             OFIFO through the SFP and writes each psum row to psum SRAM.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, rising edge
//    reset        in   asynchronous reset, active-low
//    start        in   pulse to begin a pass (ignored while busy / on done)
//    busy         out  pass in progress
//    done         out  one-cycle pulse after the final psum write
//    w_cen/w_addr out  weight SRAM enable (active-low) / address
//    a_cen/a_addr out  activation SRAM enable (active-low) / address
//    l0_wr/l0_rd  out  L0 write / read strobes
//    l0_full      in   L0 full, stalls fills
//    load/execute out  corelet instruction bits
//    ofifo_valid  in   OFIFO holds a complete row
//    ofifo_rd     out  OFIFO read strobe
//    sfu_enable   out  SFP enable, same cycle as ofifo_rd
//    p_wen/p_addr out  psum SRAM write enable (active-low) / address
//    kij          out  current kernel position
// ============================================================================
module corelet_ctrl #(
    parameter int ROW      = 8,
    parameter int COL      = 8,
    parameter int KIJ_NUM  = 9,
    parameter int LEN_NIJ  = 36,
    parameter int LOAD_GAP = 16,
    parameter int AW       = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          w_cen,
    output logic [AW-1:0] w_addr,
    output logic          a_cen,
    output logic [AW-1:0] a_addr,
    output logic          l0_wr,
    output logic          l0_rd,
    input  logic          l0_full,
    output logic          load,
    output logic          execute,
    input  logic          ofifo_valid,
    output logic          ofifo_rd,
    output logic          sfu_enable,
    output logic          p_wen,
    output logic [AW-1:0] p_addr,
    output logic [3:0]    kij
);

    // The phase counter is shared by every state, so it must hold the
    // largest per-state count.
    localparam int c_max_a   = (ROW > COL) ? ROW : COL;
    localparam int c_max_b   = (LOAD_GAP > LEN_NIJ) ? LOAD_GAP : LEN_NIJ;
    localparam int c_cnt_max = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int c_cw      = $clog2(c_cnt_max + 1);

    localparam logic [c_cw-1:0] c_one      = c_cw'(1);
    localparam logic [c_cw-1:0] c_row_last = c_cw'(ROW - 1);
    localparam logic [c_cw-1:0] c_gap_last = c_cw'(LOAD_GAP - 1);
    localparam logic [c_cw-1:0] c_len_last = c_cw'(LEN_NIJ - 1);
    localparam logic [c_cw-1:0] c_len      = c_cw'(LEN_NIJ);
    localparam logic [AW-1:0]   c_row_aw   = AW'(ROW);
    localparam logic [AW-1:0]   c_plast_aw = AW'(LEN_NIJ - 1);
    localparam logic [3:0]      c_kij_last = 4'(KIJ_NUM - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_w_fill = 3'd1;
    localparam logic [2:0] c_st_w_load = 3'd2;
    localparam logic [2:0] c_st_w_gap  = 3'd3;
    localparam logic [2:0] c_st_a_fill = 3'd4;
    localparam logic [2:0] c_st_exec   = 3'd5;
    localparam logic [2:0] c_st_drain  = 3'd6;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] r_rd;
    logic [3:0]      r_kij;
    logic            r_p_wen;
    logic [AW-1:0]   r_p_addr;
    logic            r_done;
    logic            w_cnt_inc;
    logic            w_cnt_clr;
    logic            w_accept;
    logic            w_last_wr;

    // A start coinciding with the done pulse is dropped.
    assign w_accept  = (r_state == c_st_idle) && start && !r_done;
    // The final psum row of a kij lands one cycle after its OFIFO read.
    assign w_last_wr = (r_state == c_st_drain) && !r_p_wen && (r_p_addr == c_plast_aw);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        busy        = (r_state != c_st_idle);
        w_cen       = 1'b1;
        w_addr      = '0;
        a_cen       = 1'b1;
        a_addr      = '0;
        l0_wr       = 1'b0;
        l0_rd       = 1'b0;
        load        = 1'b0;
        execute     = 1'b0;
        ofifo_rd    = 1'b0;
        sfu_enable  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = c_st_w_fill;
                    w_cnt_clr   = 1'b1;
                end
            end
            c_st_w_fill: begin
                // Address stays visible during a stall so the next issue resumes at i.
                w_addr = (AW'(r_kij) * c_row_aw) + AW'(r_cnt);
                if (!l0_full) begin
                    w_cen = 1'b0;
                    l0_wr = 1'b1;
                    if (r_cnt == c_row_last) begin
                        w_state_nxt = c_st_w_load;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            c_st_w_load: begin
                l0_rd = 1'b1;
                load  = 1'b1;
                if (r_cnt == c_row_last) begin
                    w_state_nxt = c_st_w_gap;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            c_st_w_gap: begin
                if (r_cnt == c_gap_last) begin
                    w_state_nxt = c_st_a_fill;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            c_st_a_fill: begin
                a_addr = AW'(r_cnt);
                if (!l0_full) begin
                    a_cen = 1'b0;
                    l0_wr = 1'b1;
                    if (r_cnt == c_len_last) begin
                        w_state_nxt = c_st_exec;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            c_st_exec: begin
                l0_rd   = 1'b1;
                execute = 1'b1;
                if (r_cnt == c_len_last) begin
                    w_state_nxt = c_st_drain;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            c_st_drain: begin
                // Reads stop once every row of this kij has been taken, so a
                // permanently valid OFIFO cannot over-read.
                ofifo_rd   = ofifo_valid && (r_rd != c_len);
                sfu_enable = ofifo_rd;
                if (w_last_wr) begin
                    w_state_nxt = (r_kij == c_kij_last) ? c_st_idle : c_st_w_fill;
                    w_cnt_clr   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_rd     <= '0;
            r_kij    <= '0;
            r_p_wen  <= 1'b1;
            r_p_addr <= '0;
            r_done   <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + c_one;
            end

            if (w_accept) begin
                r_kij <= '0;
            end else if (w_last_wr && (r_kij != c_kij_last)) begin
                r_kij <= r_kij + 4'd1;
            end

            if (r_state != c_st_drain) begin
                r_rd <= '0;
            end else if (ofifo_rd) begin
                r_rd <= r_rd + c_one;
            end

            // SFP has one cycle of latency: the write trails the read.
            r_p_wen <= !ofifo_rd;
            if (ofifo_rd) begin
                r_p_addr <= AW'(r_rd);
            end

            r_done <= w_last_wr && (r_kij == c_kij_last);
        end
    end

    assign p_wen  = r_p_wen;
    assign p_addr = r_p_addr;
    assign done   = r_done;
    assign kij    = r_kij;

endmodule
`default_nettype wire

// File: tb/tb_corelet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_corelet_ctrl
//  Purpose  : Directed, table-driven bench for corelet_ctrl. Per-cycle
//             expected-output records are built from the pass timing
//             (8 fill, 8 load, 16 gap, 36 fill, 36 exec, drain) and compared
//             on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_corelet_ctrl;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          w_cen;
    logic [AW-1:0] w_addr;
    logic          a_cen;
    logic [AW-1:0] a_addr;
    logic          l0_wr;
    logic          l0_rd;
    logic          l0_full;
    logic          load;
    logic          execute;
    logic          ofifo_valid;
    logic          ofifo_rd;
    logic          sfu_enable;
    logic          p_wen;
    logic [AW-1:0] p_addr;
    logic [3:0]    kij;

    corelet_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .w_cen      (w_cen),
        .w_addr     (w_addr),
        .a_cen      (a_cen),
        .a_addr     (a_addr),
        .l0_wr      (l0_wr),
        .l0_rd      (l0_rd),
        .l0_full    (l0_full),
        .load       (load),
        .execute    (execute),
        .ofifo_valid(ofifo_valid),
        .ofifo_rd   (ofifo_rd),
        .sfu_enable (sfu_enable),
        .p_wen      (p_wen),
        .p_addr     (p_addr),
        .kij        (kij)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic          l0_full;
        logic          ofifo_valid;
        logic          busy;
        logic          done;
        logic          w_cen;
        logic          a_cen;
        logic          l0_wr;
        logic          l0_rd;
        logic          load;
        logic          execute;
        logic          ofifo_rd;
        logic          sfu;
        logic          p_wen;
        logic [AW-1:0] w_addr;
        logic [AW-1:0] a_addr;
        logic [AW-1:0] p_addr;
        logic [3:0]    kij;
        logic          chk_all;  // compare every address and kij
        logic          chk_w;    // compare w_addr even with w_cen high
    } vec_t;

    vec_t q[$];
    int   vecs        = 0;
    int   miscompares = 0;
    int   w_wr_cnt    = 0;
    int   p_wr_cnt    = 0;
    logic prev_ord    = 1'b0;

    function automatic vec_t quiet(input int k);
        vec_t v;
        v.start = 1'b0; v.l0_full = 1'b0; v.ofifo_valid = 1'b1;
        v.busy = 1'b1; v.done = 1'b0; v.w_cen = 1'b1; v.a_cen = 1'b1;
        v.l0_wr = 1'b0; v.l0_rd = 1'b0; v.load = 1'b0; v.execute = 1'b0;
        v.ofifo_rd = 1'b0; v.sfu = 1'b0; v.p_wen = 1'b1;
        v.w_addr = '0; v.a_addr = '0; v.p_addr = '0; v.kij = 4'(k);
        v.chk_all = 1'b0; v.chk_w = 1'b0;
        return v;
    endfunction

    function automatic vec_t idle_v(input logic st, input logic dn);
        vec_t v;
        v = quiet(0);
        v.busy = 1'b0; v.done = dn; v.start = st;
        return v;
    endfunction

    function automatic vec_t rst_v();
        vec_t v;
        v = idle_v(1'b0, 1'b0);
        v.chk_all = 1'b1;
        return v;
    endfunction

    function automatic vec_t wfill(input int k, input int i);
        vec_t v;
        v = quiet(k);
        v.w_cen = 1'b0; v.l0_wr = 1'b1; v.w_addr = AW'(k * 8 + i);
        return v;
    endfunction

    function automatic vec_t wload(input int k);
        vec_t v;
        v = quiet(k);
        v.l0_rd = 1'b1; v.load = 1'b1;
        return v;
    endfunction

    // W_FILL through EXEC of one kij, optionally with a stray start in EXEC.
    function automatic void gen_front(input int k, input bit stray_start);
        vec_t v;
        for (int i = 0; i < 8; i++) q.push_back(wfill(k, i));
        for (int i = 0; i < 8; i++) q.push_back(wload(k));
        for (int i = 0; i < 16; i++) q.push_back(quiet(k));
        for (int n = 0; n < 36; n++) begin
            v = quiet(k);
            v.a_cen = 1'b0; v.l0_wr = 1'b1; v.a_addr = AW'(n);
            q.push_back(v);
        end
        for (int n = 0; n < 36; n++) begin
            v = quiet(k);
            v.l0_rd = 1'b1; v.execute = 1'b1;
            if (stray_start && n == 5) v.start = 1'b1;
            q.push_back(v);
        end
    endfunction

    // DRAIN of one kij. pat 0: valid always; pat 1: valid 1,0,0 repeating.
    function automatic void gen_drain(input int k, input int pat);
        vec_t v;
        int   reads = 0;
        int   idx   = 0;
        bit   pr    = 1'b0;
        bit   rd;
        for (int c = 0; c < 400; c++) begin
            v = quiet(k);
            v.ofifo_valid = (pat == 0) ? 1'b1 : ((c % 3) == 0);
            rd = v.ofifo_valid && (reads < 36);
            v.ofifo_rd = rd; v.sfu = rd;
            v.p_wen = !pr; v.p_addr = AW'(idx);
            q.push_back(v);
            if (pr && idx == 35) break;
            pr = rd;
            if (rd) begin
                idx = reads;
                reads++;
            end
        end
    endfunction

    task automatic check(input vec_t v, input string nm, input int n);
        bit ok;
        ok = (busy === v.busy) && (done === v.done) && (w_cen === v.w_cen) &&
             (a_cen === v.a_cen) && (l0_wr === v.l0_wr) && (l0_rd === v.l0_rd) &&
             (load === v.load) && (execute === v.execute) &&
             (ofifo_rd === v.ofifo_rd) && (sfu_enable === v.sfu) && (p_wen === v.p_wen);
        if (!v.w_cen || v.chk_w || v.chk_all) ok = ok && (w_addr === v.w_addr);
        if (!v.a_cen || v.chk_all) ok = ok && (a_addr === v.a_addr);
        if (!v.p_wen || v.chk_all) ok = ok && (p_addr === v.p_addr);
        if (v.busy || v.chk_all) ok = ok && (kij === v.kij);
        vecs++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s[%0d]: actual busy=%b done=%b wcen=%b waddr=%0d acen=%b aaddr=%0d wr=%b rd=%b ld=%b ex=%b ord=%b sfu=%b pwen=%b paddr=%0d kij=%0d ; required busy=%b done=%b wcen=%b waddr=%0d acen=%b aaddr=%0d wr=%b rd=%b ld=%b ex=%b ord=%b sfu=%b pwen=%b paddr=%0d kij=%0d",
                     nm, n, busy, done, w_cen, w_addr, a_cen, a_addr, l0_wr, l0_rd, load, execute,
                     ofifo_rd, sfu_enable, p_wen, p_addr, kij,
                     v.busy, v.done, v.w_cen, v.w_addr, v.a_cen, v.a_addr, v.l0_wr, v.l0_rd,
                     v.load, v.execute, v.ofifo_rd, v.sfu, v.p_wen, v.p_addr, v.kij);
        end
        if (reset) begin
            if ((load && execute) || (l0_wr && l0_rd) || (!p_wen && !prev_ord)) begin
                miscompares++;
                $display("FAIL invariant %s[%0d]: actual ld=%b ex=%b wr=%b rd=%b pwen=%b prev_ord=%b ; required no overlap and pwen low only after a read",
                         nm, n, load, execute, l0_wr, l0_rd, p_wen, prev_ord);
            end
            if (!w_cen) w_wr_cnt++;
            if (!p_wen) p_wr_cnt++;
        end
        prev_ord = ofifo_rd;
    endtask

    task automatic apply(input vec_t v, input string nm, input int n);
        start       = v.start;
        l0_full     = v.l0_full;
        ofifo_valid = v.ofifo_valid;
        @(negedge clk);
        check(v, nm, n);
        @(posedge clk);
        #1;
    endtask

    task automatic run_q(input string nm, input int upto);
        for (int i = 0; i < upto; i++) apply(q[i], nm, i);
    endtask

    task automatic check_count(input string nm, input int got, input int exp);
        vecs++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: actual %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        start = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check(rst_v(), "reset", 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        prev_ord = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        vec_t v;
        reset = 1'b0; start = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b1;
        do_reset();

        // Abort in EXEC of kij=2: 10 execute cycles in, then reset.
        q.delete();
        q.push_back(idle_v(1'b1, 1'b0));
        for (int k = 0; k < 2; k++) begin
            gen_front(k, 1'b0);
            gen_drain(k, 0);
        end
        gen_front(2, 1'b0);
        run_q("abort_run", q.size() - 26);
        reset = 1'b0;
        #1;
        check(rst_v(), "abort_same_cycle", 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        prev_ord = 1'b0;
        for (int i = 0; i < 3; i++) apply(idle_v(1'b0, 1'b0), "abort_no_done", i);

        // Full pass from kij 0, stray start in kij 3 EXEC, start on done ignored.
        q.delete();
        q.push_back(idle_v(1'b1, 1'b0));
        for (int k = 0; k < 9; k++) begin
            gen_front(k, k == 3);
            gen_drain(k, 0);
        end
        q.push_back(idle_v(1'b1, 1'b1));
        q.push_back(idle_v(1'b0, 1'b0));
        q.push_back(idle_v(1'b0, 1'b0));
        base = p_wr_cnt;
        run_q("full_pass", q.size());
        check_count("psum_writes_pass", p_wr_cnt - base, 324);

        // l0_full stall at i=4 of the weight fill.
        do_reset();
        q.delete();
        q.push_back(idle_v(1'b1, 1'b0));
        for (int i = 0; i < 4; i++) q.push_back(wfill(0, i));
        for (int i = 0; i < 3; i++) begin
            v = quiet(0);
            v.l0_full = 1'b1; v.chk_w = 1'b1; v.w_addr = AW'(4);
            q.push_back(v);
        end
        for (int i = 4; i < 8; i++) q.push_back(wfill(0, i));
        q.push_back(wload(0));
        base = w_wr_cnt;
        run_q("stall", q.size());
        check_count("weight_writes_stall", w_wr_cnt - base, 8);

        // Drain with ofifo_valid toggling 1,0,0; then kij 1 weight fill.
        do_reset();
        q.delete();
        q.push_back(idle_v(1'b1, 1'b0));
        gen_front(0, 1'b0);
        gen_drain(0, 1);
        q.push_back(wfill(1, 0));
        base = p_wr_cnt;
        run_q("toggle_drain", q.size());
        check_count("psum_writes_toggle", p_wr_cnt - base, 36);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
